// File: rtl/combine_net_n.sv
// N-lane update combiner: lanes sharing a destination id are reduced into the lowest such lane.
// Define CN_MIN_REDUCE_EN to reduce by unsigned minimum instead of wrap-around sum.
module combine_net_n #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        InputValid,
  input  logic [DATA_W*LANES-1:0] InDestVid,
  input  logic [DATA_W*LANES-1:0] InUpdate,
  output logic                    InReady,
  output logic [LANES-1:0]        OutValid,
  output logic [DATA_W*LANES-1:0] OutDestVid,
  output logic [DATA_W*LANES-1:0] OutUpdate,
  input  logic                    OutReady
);

  localparam int LOG_L  = $clog2(LANES);
  localparam int STAGES = LOG_L + 2;

`ifdef CN_MIN_REDUCE_EN
  localparam logic [DATA_W-1:0] IDENT = '1;
`else
  localparam logic [DATA_W-1:0] IDENT = '0;
`endif

  function automatic logic [DATA_W-1:0] reduceOp(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef CN_MIN_REDUCE_EN
    return (a < b) ? a : b;
`else
    return a + b;
`endif
  endfunction

  logic [STAGES-1:0] occReg;
  logic [STAGES-1:0] stageReady;
  logic              inFire;

  genvar gi, gj, gk;

  // A stage can load when it, or any stage below it, has room, or the output drains.
  for (gk = 0; gk < STAGES; gk++) begin : g_ready
    assign stageReady[gk] = OutReady || !(&occReg[STAGES-1:gk]);
  end

  assign InReady = !rst && stageReady[0];
  assign inFire  = (|InputValid) && stageReady[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      occReg <= '0;
    end else begin
      if (stageReady[0]) occReg[0] <= inFire;
      for (int k = 1; k < STAGES; k++) begin
        if (stageReady[k]) occReg[k] <= occReg[k-1];
      end
    end
  end

  // S0: input capture
  logic [LANES-1:0]  v0Reg;
  logic [DATA_W-1:0] id0Reg  [LANES];
  logic [DATA_W-1:0] upd0Reg [LANES];

  always_ff @(posedge clk) begin
    if (stageReady[0]) begin
      v0Reg <= InputValid;
      for (int i = 0; i < LANES; i++) begin
        id0Reg[i]  <= InDestVid[i*DATA_W +: DATA_W];
        upd0Reg[i] <= InUpdate[i*DATA_W +: DATA_W];
      end
    end
  end

  // S1: match matrix
  logic [LANES-1:0]  eqNext  [LANES];
  logic [LANES-1:0]  eq1Reg  [LANES];
  logic [LANES-1:0]  v1Reg;
  logic [DATA_W-1:0] id1Reg  [LANES];
  logic [DATA_W-1:0] upd1Reg [LANES];
  logic [LANES-1:0]  firstS1;

  for (gi = 0; gi < LANES; gi++) begin : g_row
    for (gj = 0; gj < LANES; gj++) begin : g_col
      if (gi == gj) begin : g_diag
        assign eqNext[gi][gj] = 1'b0;
      end else begin : g_off
        assign eqNext[gi][gj] = v0Reg[gi] && v0Reg[gj] && (id0Reg[gi] == id0Reg[gj]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stageReady[1]) begin
      v1Reg <= v0Reg;
      for (int i = 0; i < LANES; i++) begin
        eq1Reg[i]  <= eqNext[i];
        id1Reg[i]  <= id0Reg[i];
        upd1Reg[i] <= upd0Reg[i];
      end
    end
  end

  // A lane survives only if no lower valid lane carries the same id.
  for (gi = 0; gi < LANES; gi++) begin : g_first
    if (gi == 0) begin : g_lane0
      assign firstS1[gi] = v1Reg[gi];
    end else begin : g_laneN
      assign firstS1[gi] = v1Reg[gi] && !(|eq1Reg[gi][gi-1:0]);
    end
  end

  // Level 0 is the masked operand set; each later level halves it and is one stage.
  for (gk = 0; gk <= LOG_L; gk++) begin : lvl
    localparam int W = LANES >> gk;
    logic [DATA_W-1:0] part [LANES][W];
    logic [LANES-1:0]  laneFirst;
    logic [DATA_W-1:0] laneId [LANES];

    if (gk == 0) begin : g_mask
      always_comb begin
        laneFirst = firstS1;
        for (int i = 0; i < LANES; i++) begin
          laneId[i] = id1Reg[i];
          for (int j = 0; j < LANES; j++) begin
            part[i][j] = (eq1Reg[i][j] || (i == j && v1Reg[i])) ? upd1Reg[j] : IDENT;
          end
        end
      end
    end else begin : g_reduce
      always_ff @(posedge clk) begin
        if (stageReady[gk+1]) begin
          laneFirst <= lvl[gk-1].laneFirst;
          for (int i = 0; i < LANES; i++) begin
            laneId[i] <= lvl[gk-1].laneId[i];
            for (int j = 0; j < W; j++) begin
              part[i][j] <= reduceOp(lvl[gk-1].part[i][2*j], lvl[gk-1].part[i][2*j+1]);
            end
          end
        end
      end
    end
  end

  // Gating by the last occupancy bit keeps bubbles and post-reset state all-zero.
  for (gi = 0; gi < LANES; gi++) begin : g_out
    assign OutValid[gi] = occReg[STAGES-1] && lvl[LOG_L].laneFirst[gi];
    assign OutDestVid[gi*DATA_W +: DATA_W] = OutValid[gi] ? lvl[LOG_L].laneId[gi] : '0;
    assign OutUpdate[gi*DATA_W +: DATA_W]  = OutValid[gi] ? lvl[LOG_L].part[gi][0] : '0;
  end

endmodule

// File: tb/tb_combine_net_n.sv
// Scoreboard bench for combine_net_n (LANES=8, DATA_W=32): directed beats, decoupled output monitor.
module tb_combine_net_n;
  localparam int LAT = 5;

`ifdef CN_MIN_REDUCE_EN
  localparam bit MIN_BUILD = 1'b1;
`else
  localparam bit MIN_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   InputValid = '0;
  logic [255:0] InDestVid = '0;
  logic [255:0] InUpdate = '0;
  logic         InReady;
  logic [7:0]   OutValid;
  logic [255:0] OutDestVid;
  logic [255:0] OutUpdate;
  logic         OutReady = 1'b1;

  combine_net_n #(.DATA_W(32), .LANES(8)) dut (
    .clk(clk), .rst(rst),
    .InputValid(InputValid), .InDestVid(InDestVid), .InUpdate(InUpdate), .InReady(InReady),
    .OutValid(OutValid), .OutDestVid(OutDestVid), .OutUpdate(OutUpdate), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   v;
    logic [255:0] ids;
    logic [255:0] upds;
    int           accCyc;
    bit           chkLat;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, accCount = 0, outCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sendBeat(input logic [7:0] v, input logic [255:0] ids, input logic [255:0] upds,
                          input logic [7:0] ev, input logic [255:0] eIds, input logic [255:0] eUpds,
                          input bit track, input bit lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    InputValid = v;
    InDestVid  = ids;
    InUpdate   = upds;
    #1;
    while (!InReady && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!InReady) begin
      errors++;
      $display("FAIL accept_timeout actual InReady=0 required InReady=1");
    end else begin
      accCount++;
      $display("IN  #%0d valid=%h tracked=%0d", accCount, v, track);
      if (track) begin
        e.v = ev; e.ids = eIds; e.upds = eUpds; e.accCyc = cyc; e.chkLat = lat;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    InputValid = '0;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 256'(sb.size()), 256'(0));
  endtask

  // Output monitor: compares every transferred beat against the queue head.
  logic [7:0]   heldV;
  logic [255:0] heldI, heldU;
  bit           stalled = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 256'(OutValid), 256'(heldV));
          chk("hold_id", OutDestVid, heldI);
          chk("hold_upd", OutUpdate, heldU);
        end
        stalled = 1'b0;
        if (|OutValid) begin
          if (!OutReady) begin
            stalled = 1'b1;
            heldV = OutValid; heldI = OutDestVid; heldU = OutUpdate;
          end else begin
            outCount++;
            $display("OUT #%0d valid=%h", outCount, OutValid);
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat actual valid=%h required=no beat", OutValid);
            end else begin
              e = sb.pop_front();
              chk("out_valid", 256'(OutValid), 256'(e.v));
              chk("out_id", OutDestVid, e.ids);
              chk("out_upd", OutUpdate, e.upds);
              if (e.chkLat) chk("latency", 256'(cyc - e.accCyc), 256'(LAT));
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, bpBase, n;
    logic [255:0] ids, upds;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("inready_in_reset", 256'(InReady), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("inready_after_reset", 256'(InReady), 256'(1));
    chk("reset_valid", 256'(OutValid), 256'(0));
    chk("reset_id", OutDestVid, 256'(0));
    chk("reset_upd", OutUpdate, 256'(0));

    // Distinct ids
    sendBeat(8'hFF, pk(8, 7, 6, 5, 4, 3, 2, 1), pk(1, 1, 1, 1, 1, 1, 1, 1),
             8'hFF, pk(8, 7, 6, 5, 4, 3, 2, 1), pk(1, 1, 1, 1, 1, 1, 1, 1), 1'b1, 1'b1);
    // Duplicate ids
    sendBeat(8'hFF, pk(1, 5, 1, 5, 5, 2, 2, 2), pk(1, 1, 1, 1, 1, 1, 1, 1),
             8'b0010_0011, pk(1, 5, 0, 0, 0, 2, 0, 0),
             MIN_BUILD ? pk(1, 1, 0, 0, 0, 1, 0, 0) : pk(2, 3, 0, 0, 0, 3, 0, 0), 1'b1, 1'b1);
    // Invalid lanes ignored; sum wraps
    sendBeat(8'b1000_0001, pk(9, 9, 9, 9, 9, 9, 9, 9), pk(32'hFFFF_FFFF, 7, 7, 7, 7, 7, 7, 2),
             8'h01, pk(9, 0, 0, 0, 0, 0, 0, 0),
             MIN_BUILD ? pk(2, 0, 0, 0, 0, 0, 0, 0) : pk(1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    // All ids equal: min 3, sum 51
    sendBeat(8'hFF, pk(4, 4, 4, 4, 4, 4, 4, 4), pk(9, 3, 7, 3, 8, 6, 5, 10),
             8'h01, pk(4, 0, 0, 0, 0, 0, 0, 0),
             MIN_BUILD ? pk(3, 0, 0, 0, 0, 0, 0, 0) : pk(51, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    // Invalid lane0 shares id with lane1: lane1 must still lead its group
    sendBeat(8'b1111_1110, pk(3, 3, 4, 3, 4, 0, 0, 7), pk(100, 1, 2, 4, 8, 16, 32, 64),
             8'b1010_0110, pk(0, 3, 4, 0, 0, 0, 0, 7),
             MIN_BUILD ? pk(0, 1, 2, 0, 0, 16, 0, 64) : pk(0, 5, 10, 0, 0, 48, 0, 64), 1'b1, 1'b1);
    waitDrain("drain_basic");

    // Backpressure: 7 distinct beats, output stalled from cycle 2
    @(posedge clk);
    #1;
    bpBase = accCount;
    base = outCount;
    fork
      begin
        for (int b = 0; b < 7; b++) begin
          for (int l = 0; l < 8; l++) begin
            ids[l*32 +: 32]  = 32'(16*b + l + 1);
            upds[l*32 +: 32] = 32'(100*b + l);
          end
          sendBeat(8'hFF, ids, upds, 8'hFF, ids, upds, 1'b1, 1'b0);
        end
      end
      begin
        n = 0;
        repeat (2) @(negedge clk);
        OutReady = 1'b0;
        #1;
        while (InReady && n < 20) begin
          @(negedge clk);
          #1;
          n++;
        end
        chk("inready_full", 256'(InReady), 256'(0));
        chk("held_beats_at_stall", 256'(accCount - bpBase), 256'(5));
        repeat (6) @(negedge clk);
        OutReady = 1'b1;
      end
    join
    waitDrain("drain_backpressure");
    chk("bp_out_count", 256'(outCount - base), 256'(7));

    // Bubbles between beats are never emitted
    base = outCount;
    @(posedge clk);
    #1;
    sendBeat(8'h0F, pk(1, 1, 1, 1, 0, 0, 0, 0), pk(1, 2, 3, 4, 0, 0, 0, 0),
             8'h01, pk(1, 0, 0, 0, 0, 0, 0, 0),
             MIN_BUILD ? pk(1, 0, 0, 0, 0, 0, 0, 0) : pk(10, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    InDestVid = pk(5, 5, 5, 5, 5, 5, 5, 5);
    @(posedge clk);
    #1;
    sendBeat(8'hF0, pk(0, 0, 0, 0, 2, 3, 2, 3), pk(0, 0, 0, 0, 5, 6, 7, 8),
             8'h30, pk(0, 0, 0, 0, 2, 3, 0, 0),
             MIN_BUILD ? pk(0, 0, 0, 0, 5, 6, 0, 0) : pk(0, 0, 0, 0, 12, 14, 0, 0), 1'b1, 1'b1);
    @(posedge clk);
    #1;
    sendBeat(8'hFF, pk(8, 7, 6, 5, 4, 3, 2, 1), pk(1, 1, 1, 1, 1, 1, 1, 1),
             8'hFF, pk(8, 7, 6, 5, 4, 3, 2, 1), pk(1, 1, 1, 1, 1, 1, 1, 1), 1'b1, 1'b1);
    waitDrain("drain_bubbles");
    repeat (4) @(negedge clk);
    chk("bubble_out_count", 256'(outCount - base), 256'(3));

    // Reset with 3 beats in flight: none may appear afterwards
    base = outCount;
    sendBeat(8'hFF, pk(1, 2, 3, 4, 5, 6, 7, 8), pk(1, 1, 1, 1, 1, 1, 1, 1), 8'h00, '0, '0, 1'b0, 1'b0);
    sendBeat(8'h03, pk(9, 9, 0, 0, 0, 0, 0, 0), pk(4, 4, 0, 0, 0, 0, 0, 0), 8'h00, '0, '0, 1'b0, 1'b0);
    sendBeat(8'h80, pk(0, 0, 0, 0, 0, 0, 0, 6), pk(0, 0, 0, 0, 0, 0, 0, 3), 8'h00, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("inready_mid_reset", 256'(InReady), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_valid", 256'(OutValid), 256'(0));
    chk("post_reset_id", OutDestVid, 256'(0));
    chk("post_reset_upd", OutUpdate, 256'(0));
    chk("post_reset_inready", 256'(InReady), 256'(1));
    repeat (12) @(negedge clk);
    chk("inflight_discarded", 256'(outCount - base), 256'(0));

    // Pipeline still works after the mid-stream reset
    sendBeat(8'h0C, pk(0, 0, 7, 7, 0, 0, 0, 0), pk(0, 0, 20, 30, 0, 0, 0, 0),
             8'h04, pk(0, 0, 7, 0, 0, 0, 0, 0),
             MIN_BUILD ? pk(0, 0, 20, 0, 0, 0, 0, 0) : pk(0, 0, 50, 0, 0, 0, 0, 0), 1'b1, 1'b1);
    waitDrain("drain_final");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
